// File: rtl/seg_decode_pkg.sv
// Shared types and helpers for the 7-segment bus receiver.
// Holds segment pattern constants, FSM states and decode functions.
package seg_decode_pkg;

  localparam int NUM_SLOTS = 4;

  // Active-low patterns on seg[6:0] = g..a
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] bcd;
  } bcd_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] idx;
  } slot_t;

  function automatic bcd_t seg_to_bcd(
    input logic [6:0] seg7
  );
    bcd_t r;
    r.legal = 1'b1;
    r.bcd   = 4'd0;
    case (seg7)
      SEG_0:   r.bcd = 4'd0;
      SEG_1:   r.bcd = 4'd1;
      SEG_2:   r.bcd = 4'd2;
      SEG_3:   r.bcd = 4'd3;
      SEG_4:   r.bcd = 4'd4;
      SEG_5:   r.bcd = 4'd5;
      SEG_6:   r.bcd = 4'd6;
      SEG_7:   r.bcd = 4'd7;
      SEG_8:   r.bcd = 4'd8;
      SEG_9:   r.bcd = 4'd9;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  // ok only when exactly one strobe is low
  function automatic slot_t onehot_low_idx(
    input logic [3:0] an
  );
    slot_t r;
    r.ok  = 1'b1;
    r.idx = 2'd0;
    case (an)
      4'b1110: r.idx = 2'd0;
      4'b1101: r.idx = 2'd1;
      4'b1011: r.idx = 2'd2;
      4'b0111: r.idx = 2'd3;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seg[6:0] to {legal, bcd} decoder.
// Ports: seg (in, 7, active-low g..a), legal (out), bcd (out, 4).
module seg_pattern_decode (
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] bcd
);
  import seg_decode_pkg::*;

  bcd_t r;

  assign r     = seg_to_bcd(seg);
  assign legal = r.legal;
  assign bcd   = r.bcd;

endmodule

// File: rtl/seg_display_decoder.sv
// Passive receiver for a multiplexed 4-digit 7-segment bus.
// In: clk, reset_n, seg[7:0], an[3:0]. Out: digit[15:0],
// digit_valid[3:0], blank[3:0], update, frame_done,
// bad_pattern, err_count[7:0].
module seg_display_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int BLANK_TIMEOUT = 1_000_000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digit,
  output logic [3:0]  digit_valid,
  output logic [3:0]  blank,
  output logic        update,
  output logic        frame_done,
  output logic        bad_pattern,
  output logic [7:0]  err_count
);
  import seg_decode_pkg::*;

  localparam int SW =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int BW = $clog2(BLANK_TIMEOUT + 1);

  localparam logic [SW-1:0] STAB_LAST =
    SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);
  localparam logic [BW-1:0] BLANK_MAX =
    BW'(BLANK_TIMEOUT);
  localparam logic [BW-1:0] BLANK_ONE = BW'(1);

  logic [SYNC_STAGES-1:0][3:0] an_sr;
  logic [SYNC_STAGES-1:0][6:0] seg_sr;
  logic [3:0]  an_s;
  logic [6:0]  seg_s;
  logic [10:0] bus_s;
  logic [10:0] bus_q;
  logic        changed;

  slot_t       slot;
  logic [3:0]  slot_mask;
  logic        dec_legal;
  logic [3:0]  dec_bcd;

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] stab_cnt;
  logic [SW-1:0] stab_nx;
  logic          do_cap;

  logic [3:0]    seen;
  logic [3:0]    seen_nx;
  logic [3:0][BW-1:0] blank_cnt;

  // decimal point carries no digit information
  logic dp_unused;
  assign dp_unused = seg[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_sr  <= '0;
      seg_sr <= '0;
    end else begin
      an_sr  <= {an_sr[SYNC_STAGES-2:0], an};
      seg_sr <= {seg_sr[SYNC_STAGES-2:0], seg[6:0]};
    end
  end

  assign an_s    = an_sr[SYNC_STAGES-1];
  assign seg_s   = seg_sr[SYNC_STAGES-1];
  assign bus_s   = {an_s, seg_s};
  assign changed = (bus_s != bus_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus_q <= '0;
    else          bus_q <= bus_s;
  end

  assign slot      = onehot_low_idx(an_s);
  assign slot_mask =
    slot.ok ? (4'b0001 << slot.idx) : 4'b0000;

  seg_pattern_decode u_dec (
    .seg   (seg_s),
    .legal (dec_legal),
    .bcd   (dec_bcd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      stab_cnt <= '0;
    end else begin
      state    <= state_nx;
      stab_cnt <= stab_nx;
    end
  end

  // Capture fires on the edge that enters CAPTURE, so the
  // registered pulses are visible during the CAPTURE cycle.
  always_comb begin
    state_nx = state;
    stab_nx  = stab_cnt;
    do_cap   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (slot.ok) begin
          state_nx = ST_SETTLE;
          stab_nx  = '0;
        end
      end
      ST_SETTLE: begin
        if (changed) begin
          stab_nx  = '0;
          state_nx = slot.ok ? ST_SETTLE : ST_IDLE;
        end else if (stab_cnt == STAB_LAST) begin
          state_nx = ST_CAPTURE;
          do_cap   = 1'b1;
        end else begin
          stab_nx = stab_cnt + STAB_ONE;
        end
      end
      ST_CAPTURE, ST_HOLD: begin
        if (changed) begin
          stab_nx  = '0;
          state_nx = slot.ok ? ST_SETTLE : ST_IDLE;
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        stab_nx  = '0;
      end
    endcase
  end

  assign seen_nx = seen | slot_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit       <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      frame_done  <= 1'b0;
      bad_pattern <= 1'b0;
      err_count   <= '0;
      seen        <= '0;
    end else begin
      update      <= 1'b0;
      frame_done  <= 1'b0;
      bad_pattern <= 1'b0;
      if (do_cap) begin
        if (dec_legal) begin
          digit[{slot.idx, 2'b00} +: 4] <= dec_bcd;
          digit_valid <= digit_valid | slot_mask;
          update      <= 1'b1;
          if (seen_nx == 4'hF) begin
            frame_done <= 1'b1;
            seen       <= '0;
          end else begin
            seen <= seen_nx;
          end
        end else begin
          bad_pattern <= 1'b1;
          if (err_count != 8'hFF)
            err_count <= err_count + 8'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_blank
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        blank_cnt[g] <= '0;
      else if (slot_mask[g])
        blank_cnt[g] <= '0;
      else if (blank_cnt[g] < BLANK_MAX)
        blank_cnt[g] <= blank_cnt[g] + BLANK_ONE;
    end
    assign blank[g] = (blank_cnt[g] >= BLANK_MAX);
  end

endmodule

// File: tb/tb_seg_display_decoder.sv
// Bench for seg_display_decoder: directed steps plus
// randomized captures checked against a digit-level model.
module tb_seg_display_decoder;

  logic        clk;
  logic        reset_n;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] digit;
  logic [3:0]  digit_valid;
  logic [3:0]  blank;
  logic        update;
  logic        frame_done;
  logic        bad_pattern;
  logic [7:0]  err_count;

  seg_display_decoder #(
    .STABLE_CYCLES (4),
    .BLANK_TIMEOUT (64),
    .SYNC_STAGES   (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg         (seg),
    .an          (an),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .update      (update),
    .frame_done  (frame_done),
    .bad_pattern (bad_pattern),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int n_upd = 0;
  int n_bad = 0;
  int n_frm = 0;

  always @(negedge clk) begin
    if (update)      n_upd++;
    if (bad_pattern) n_bad++;
    if (frame_done)  n_frm++;
  end

  logic [6:0] tbl [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic [3:0]  m_dig [4];
  logic [3:0]  m_valid;
  logic [3:0]  m_seen;
  int          m_err;
  logic [10:0] m_prev;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_update(
    input  int maxc,
    output int first
  );
    first = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge clk);
      #1;
      if (update && first == 0) first = k;
    end
  endtask

  function automatic void ref_decode(
    input  logic [6:0] s,
    output logic       ok,
    output logic [3:0] v
  );
    ok = 1'b0;
    v  = 4'd0;
    for (int i = 0; i < 10; i++)
      if (tbl[i] == s) begin
        ok = 1'b1;
        v  = 4'(i);
      end
  endfunction

  function automatic logic [15:0] m_word();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first;
    int          u0;
    int          b0;
    int          f0;
    int          r;
    int          eu;
    int          eb;
    int          ef;
    logic [3:0]  a;
    logic [6:0]  s;
    logic        ok;
    logic [3:0]  v;
    logic [6:0]  p2 [4];

    // 1: reset values and first capture latency
    reset_n = 1'b1;
    an      = 4'hE;
    seg     = 8'h79;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs",
        64'({digit, digit_valid, blank, update,
             frame_done, bad_pattern, err_count}),
        64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    u0 = n_upd;
    wait_update(12, first);
    chk("t1_latency", 64'(first), 64'd7);
    chk("t1_upd_cnt", 64'(n_upd - u0), 64'd1);
    chk("t1_digit", 64'(digit), 64'h0001);
    chk("t1_valid", 64'(digit_valid), 64'b0001);

    // 2: full frame
    p2[0] = 7'h12;
    p2[1] = 7'h30;
    p2[2] = 7'h19;
    p2[3] = 7'h40;
    for (int sl = 0; sl < 4; sl++) begin
      f0  = n_frm;
      an  = ~(4'b0001 << sl);
      seg = {1'b0, p2[sl]};
      tick(20);
      chk($sformatf("t2_frame_s%0d", sl),
          64'(n_frm - f0),
          (sl == 3) ? 64'd1 : 64'd0);
    end
    chk("t2_digit", 64'(digit), 64'h0435);
    chk("t2_valid", 64'(digit_valid), 64'hF);

    // 3: glitch filter
    u0 = n_upd;
    an = 4'hD;
    for (int t = 0; t < 7; t++) begin
      seg = (t % 2 == 0) ? 8'h24 : 8'h30;
      tick(3);
    end
    chk("t3_no_upd", 64'(n_upd - u0), 64'd0);
    seg = 8'h30;
    wait_update(12, first);
    chk("t3_latency", 64'(first), 64'd7);
    chk("t3_digit1", 64'(digit[7:4]), 64'd3);

    // random captures against the model
    m_dig[0] = 4'd5;
    m_dig[1] = 4'd3;
    m_dig[2] = 4'd4;
    m_dig[3] = 4'd0;
    m_valid  = 4'hF;
    m_seen   = 4'b0010;
    m_err    = 0;
    m_prev   = {4'hD, 7'h30};
    for (int st = 0; st < 40; st++) begin
      r = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 4'hF;
      else a = ~(4'b0001 << r);
      if ($urandom_range(0, 3) != 0)
        s = tbl[$urandom_range(0, 9)];
      else
        s = 7'($urandom);
      eu = 0;
      eb = 0;
      ef = 0;
      if (a != 4'hF && {a, s} != m_prev) begin
        ref_decode(s, ok, v);
        if (ok) begin
          m_dig[r]   = v;
          m_valid[r] = 1'b1;
          m_seen[r]  = 1'b1;
          eu = 1;
          if (m_seen == 4'hF) begin
            ef     = 1;
            m_seen = 4'h0;
          end
        end else begin
          eb = 1;
          if (m_err < 255) m_err++;
        end
      end
      m_prev = {a, s};
      u0 = n_upd;
      b0 = n_bad;
      f0 = n_frm;
      an  = a;
      seg = {1'($urandom), s};
      tick(10);
      chk("rnd_upd", 64'(n_upd - u0), 64'(eu));
      chk("rnd_bad", 64'(n_bad - b0), 64'(eb));
      chk("rnd_frame", 64'(n_frm - f0), 64'(ef));
      chk("rnd_digit", 64'(digit), 64'(m_word()));
      chk("rnd_valid", 64'(digit_valid), 64'(m_valid));
      chk("rnd_err", 64'(err_count), 64'(m_err));
    end

    // 4: illegal pattern and saturation
    an = 4'hF;
    tick(10);
    u0  = n_upd;
    b0  = n_bad;
    an  = 4'hB;
    seg = 8'h55;
    tick(10);
    if (m_err < 255) m_err++;
    chk("t4_bad_once", 64'(n_bad - b0), 64'd1);
    chk("t4_no_upd", 64'(n_upd - u0), 64'd0);
    chk("t4_err", 64'(err_count), 64'(m_err));
    chk("t4_digit2", 64'(digit[11:8]), 64'(m_dig[2]));
    for (int k = 1; k < 300; k++) begin
      seg = (k % 2 == 1) ? 8'h7F : 8'h55;
      tick(8);
    end
    chk("t4_err_sat", 64'(err_count), 64'd255);
    chk("t4_digit_keep", 64'(digit), 64'(m_word()));

    // 5: blanking of withheld slots
    for (int p = 0; p < 8; p++) begin
      an  = (p % 2 == 0) ? 4'hE : 4'hD;
      seg = (p % 2 == 0) ? 8'h79 : 8'h24;
      tick(10);
    end
    m_dig[0] = 4'd1;
    m_dig[1] = 4'd2;
    chk("t5_blank", 64'(blank), 64'b1100);
    chk("t5_keep_hi", 64'(digit[15:8]),
        64'({m_dig[3], m_dig[2]}));
    an  = 4'hB;
    seg = 8'h19;
    tick(2);
    chk("t5_blank2_hold", 64'(blank[2]), 64'd1);
    tick(1);
    chk("t5_blank2_clr", 64'(blank[2]), 64'd0);
    tick(10);

    // 6: reset during SETTLE on slot 3
    an  = 4'h7;
    seg = 8'h10;
    tick(4);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_async_clr",
        64'({digit, digit_valid, blank, update,
             frame_done, bad_pattern, err_count}),
        64'd0);
    u0 = n_upd;
    f0 = n_frm;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_in_reset", 64'(n_upd - u0), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_update(12, first);
    chk("t6_latency", 64'(first), 64'd7);
    chk("t6_no_frame", 64'(n_frm - f0), 64'd0);
    chk("t6_digit", 64'(digit), 64'h9000);
    chk("t6_valid", 64'(digit_valid), 64'b1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
